// File: rtl/alu_writeback_if.sv
// Bundle between the ALU and its writeback stage. It carries the result
// handshake plus the two asynchronous register-file read ports used by
// the operand-fetch logic.
interface alu_writeback_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          Opcode;
  logic [2*DATA_W-1:0] Result;
  logic                flagC;
  logic                flagZ;
  logic [ADDR_W-1:0]   DestAddr;
  logic [ADDR_W-1:0]   RdAddrA;
  logic [ADDR_W-1:0]   RdAddrB;
  logic [DATA_W-1:0]   RdDataA;
  logic [DATA_W-1:0]   RdDataB;
  logic [1:0]          FlagReg;
  logic                wb_done;

  // Upstream side: ALU result producer and operand-fetch read addresses.
  modport master (
    output in_valid, Opcode, Result, flagC, flagZ, DestAddr, RdAddrA, RdAddrB,
    input  in_ready, RdDataA, RdDataB, FlagReg, wb_done
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, Opcode, Result, flagC, flagZ, DestAddr, RdAddrA, RdAddrB,
    output in_ready, RdDataA, RdDataB, FlagReg, wb_done
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures a completed ALU operation, writes the low
// byte (and for MUL the high byte on the following cycle) into a small
// register file, and keeps the {C, Z} flag register. Reads are
// combinational with no bypass, so a write becomes visible one cycle later.
module alu_writeback #(
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_writeback_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  logic [1:0]          state_reg;
  logic [1:0]          state_next;
  logic [2:0]          op_reg;
  logic [2*DATA_W-1:0] result_reg;
  logic                c_reg;
  logic                z_reg;
  logic [ADDR_W-1:0]   dest_reg;
  logic [ADDR_W-1:0]   hi_addr;
  logic [1:0]          flag_reg;
  logic                op_is_mul;
  logic                accept;
  logic                ready;
  logic                wr_lo;
  logic                wr_hi;
  logic [DATA_W-1:0]   reg_view [REG_COUNT];

  assign op_is_mul = (op_reg == OP_MUL);
  // REG_COUNT is a power of two, so natural overflow gives the 7+1 -> 0 wrap.
  assign hi_addr   = dest_reg + ADDR_W'(1);
  // Writes are gated by rst so a reset edge never modifies a register.
  assign wr_lo     = !rst && (state_reg == WR_LO);
  assign wr_hi     = !rst && (state_reg == WR_HI);

  // Handshake, completion pulse and next-state selection.
  always_comb begin
    ready      = 1'b0;
    state_next = state_reg;
    if (!rst) begin
      ready = (state_reg == IDLE) || ((state_reg == WR_LO) && !op_is_mul);
    end
    accept = bus.in_valid && ready;
    case (state_reg)
      IDLE:    state_next = accept ? WR_LO : IDLE;
      WR_LO:   begin
        if (op_is_mul)   state_next = WR_HI;
        else if (accept) state_next = WR_LO;
        else             state_next = IDLE;
      end
      WR_HI:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = ready;
  assign bus.wb_done  = !rst && (((state_reg == WR_LO) && !op_is_mul) ||
                                 (state_reg == WR_HI));
  assign bus.FlagReg  = flag_reg;

  // State register and capture latches for the accepted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      result_reg <= '0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b0;
      dest_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg     <= bus.Opcode;
        result_reg <= bus.Result;
        c_reg      <= bus.flagC;
        z_reg      <= bus.flagZ;
        dest_reg   <= bus.DestAddr;
      end
    end
  end

  // Flag register: Z follows every op, C only ADD/SUB; updated on the low write.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg <= 2'b00;
    end else if (wr_lo) begin
      flag_reg[0] <= z_reg;
      if ((op_reg == OP_ADD) || (op_reg == OP_SUB)) begin
        flag_reg[1] <= c_reg;
      end
    end
  end

  // One independent register per entry; low byte to Dest, high byte to Dest+1.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : gen_reg
      logic [DATA_W-1:0] data_reg;

      // Register gi: cleared by reset, loaded by whichever write targets it.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (wr_lo && (dest_reg == ADDR_W'(gi))) begin
          data_reg <= result_reg[DATA_W-1:0];
        end else if (wr_hi && (hi_addr == ADDR_W'(gi))) begin
          data_reg <= result_reg[2*DATA_W-1:DATA_W];
        end
      end

      assign reg_view[gi] = data_reg;
    end
  endgenerate

  assign bus.RdDataA = reg_view[bus.RdAddrA];
  assign bus.RdDataB = reg_view[bus.RdAddrB];

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: reset, a table of single operations, directed
// multi-cycle corner sequences, then randomized traffic against a
// timed-event reference model.
module tb_alu_writeback;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_writeback_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  alu_writeback #(.REG_COUNT(8), .ADDR_W(3), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic [2:0]  dest;
    logic [7:0]  exp_lo;
    logic [2:0]  other;
    logic [7:0]  exp_other;
    logic [1:0]  exp_flags;
  } vec_t;

  typedef struct {
    int         vis;
    bit         is_flag;
    int         addr;
    logic [7:0] data;
    bit         upd_c;
    bit         c;
    bit         z;
  } ev_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.Opcode   = 3'd0;
    bus.Result   = 16'd0;
    bus.flagC    = 1'b0;
    bus.flagZ    = 1'b0;
    bus.DestAddr = 3'd0;
    bus.RdAddrA  = 3'd0;
    bus.RdAddrB  = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [15:0] res,
                          input logic c, input logic z, input logic [2:0] dest);
    bus.in_valid = 1'b1;
    bus.Opcode   = op;
    bus.Result   = res;
    bus.flagC    = c;
    bus.flagZ    = z;
    bus.DestAddr = dest;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i += 2) begin
      bus.RdAddrA = 3'(i);
      bus.RdAddrB = 3'(i + 1);
      #1;
      chk($sformatf("%s_r%0d", tag, i), bus.RdDataA, 16'h0);
      chk($sformatf("%s_r%0d", tag, i + 1), bus.RdDataB, 16'h0);
    end
  endtask

  // Apply one table vector from IDLE and check its timing and results.
  task automatic run_vec(input int idx, input vec_t v);
    logic [2:0] rdy;
    logic [2:0] dn;
    bit         is_mul;
    is_mul = (v.op == OP_MUL);
    drive_op(v.op, v.res, v.c, v.z, v.dest);
    chk($sformatf("vec%0d_ready_at_accept", idx), bus.in_ready, 16'h1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = bus.in_ready;
      dn[i]  = bus.wb_done;
      tick();
    end
    chk($sformatf("vec%0d_ready_pattern", idx), rdy, is_mul ? 16'h4 : 16'h7);
    chk($sformatf("vec%0d_done_pattern", idx), dn, is_mul ? 16'h2 : 16'h1);
    bus.RdAddrA = v.dest;
    bus.RdAddrB = v.other;
    #1;
    chk($sformatf("vec%0d_lo", idx), bus.RdDataA, v.exp_lo);
    chk($sformatf("vec%0d_other", idx), bus.RdDataB, v.exp_other);
    chk($sformatf("vec%0d_flags", idx), bus.FlagReg, v.exp_flags);
  endtask

  // Reference model state for the randomized phase.
  ev_t        evq[$];
  int         done_q[$];
  logic [7:0] m_regs [8];
  logic [1:0] m_flags;
  int         busy_until;

  task automatic run_random(input int n_cycles);
    ev_t        keep[$];
    ev_t        e;
    bit         hold;
    bit         exp_done;
    bit         exp_ready;
    logic [2:0] d;
    hold = 1'b0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      // Retire every model event that has become visible by this cycle.
      keep = {};
      foreach (evq[k]) begin
        if (evq[k].vis <= cyc) begin
          if (evq[k].is_flag) begin
            m_flags[0] = evq[k].z;
            if (evq[k].upd_c) m_flags[1] = evq[k].c;
          end else begin
            m_regs[evq[k].addr] = evq[k].data;
          end
        end else begin
          keep.push_back(evq[k]);
        end
      end
      evq = keep;

      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.Opcode   = 3'($urandom_range(0, 7));
        bus.Result   = 16'($urandom);
        bus.flagC    = 1'($urandom);
        bus.flagZ    = 1'($urandom);
        bus.DestAddr = 3'($urandom_range(0, 7));
      end
      bus.RdAddrA = 3'($urandom_range(0, 7));
      bus.RdAddrB = ($urandom_range(0, 4) == 0) ? bus.RdAddrA : 3'($urandom_range(0, 7));
      #1;

      exp_ready = (cyc > busy_until);
      exp_done  = 1'b0;
      foreach (done_q[k]) if (done_q[k] == cyc) exp_done = 1'b1;
      chk($sformatf("rnd%0d_ready", cyc), bus.in_ready, exp_ready);
      chk($sformatf("rnd%0d_done", cyc), bus.wb_done, exp_done);
      chk($sformatf("rnd%0d_flags", cyc), bus.FlagReg, m_flags);
      chk($sformatf("rnd%0d_rda", cyc), bus.RdDataA, m_regs[bus.RdAddrA]);
      chk($sformatf("rnd%0d_rdb", cyc), bus.RdDataB, m_regs[bus.RdAddrB]);

      if (bus.in_valid && exp_ready) begin
        d = bus.DestAddr;
        e = '{vis: cyc + 2, is_flag: 1'b0, addr: int'(d), data: bus.Result[7:0],
              upd_c: 1'b0, c: 1'b0, z: 1'b0};
        evq.push_back(e);
        e = '{vis: cyc + 2, is_flag: 1'b1, addr: 0, data: 8'h00,
              upd_c: (bus.Opcode == OP_ADD) || (bus.Opcode == OP_SUB),
              c: bus.flagC, z: bus.flagZ};
        evq.push_back(e);
        if (bus.Opcode == OP_MUL) begin
          e = '{vis: cyc + 3, is_flag: 1'b0, addr: (int'(d) + 1) % 8,
                data: bus.Result[15:8], upd_c: 1'b0, c: 1'b0, z: 1'b0};
          evq.push_back(e);
          busy_until = cyc + 2;
          done_q.push_back(cyc + 2);
        end else begin
          done_q.push_back(cyc + 1);
        end
        hold = 1'b0;
      end else begin
        hold = bus.in_valid;
      end
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{OP_ADD,  16'h012C, 1'b1, 1'b0, 3'd3, 8'h2C, 3'd4, 8'h00, 2'b10};
    vecs[1] = '{OP_MUL,  16'hBEEF, 1'b0, 1'b0, 3'd7, 8'hEF, 3'd0, 8'hBE, 2'b10};
    vecs[2] = '{OP_SUB,  16'h0000, 1'b0, 1'b1, 3'd1, 8'h00, 3'd2, 8'h00, 2'b01};
    vecs[3] = '{OP_OR,   16'hFF80, 1'b1, 1'b0, 3'd6, 8'h80, 3'd7, 8'hEF, 2'b00};
    vecs[4] = '{OP_XOR,  16'h00A5, 1'b1, 1'b0, 3'd0, 8'hA5, 3'd1, 8'h00, 2'b00};
    vecs[5] = '{OP_ADD,  16'h0100, 1'b1, 1'b0, 3'd5, 8'h00, 3'd6, 8'h80, 2'b10};
    vecs[6] = '{OP_MUL,  16'h1234, 1'b0, 1'b0, 3'd2, 8'h34, 3'd3, 8'h12, 2'b10};
    vecs[7] = '{OP_NOR,  16'h0000, 1'b0, 1'b1, 3'd4, 8'h00, 3'd5, 8'h00, 2'b11};
    vecs[8] = '{OP_NAND, 16'hFF01, 1'b0, 1'b0, 3'd3, 8'h01, 3'd4, 8'h00, 2'b10};
    vecs[9] = '{OP_SUB,  16'h00FF, 1'b0, 1'b0, 3'd7, 8'hFF, 3'd0, 8'hA5, 2'b00};

    // Reset: outputs quiet during reset, everything cleared afterwards.
    rst = 1'b1;
    idle_inputs();
    tick();
    chk("rst_in_ready", bus.in_ready, 16'h0);
    chk("rst_wb_done", bus.wb_done, 16'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 16'h1);
    chk("post_rst_wb_done", bus.wb_done, 16'h0);
    chk("post_rst_flags", bus.FlagReg, 16'h0);
    check_all_zero("post_rst");
    tick();

    // Table of isolated operations, each started from IDLE.
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-to-back: ADD then AND accepted on consecutive cycles.
    do_reset();
    drive_op(OP_ADD, 16'h0011, 1'b1, 1'b0, 3'd2);
    tick();
    drive_op(OP_AND, 16'h0000, 1'b0, 1'b1, 3'd4);
    chk("b2b_ready_in_wr_lo", bus.in_ready, 16'h1);
    chk("b2b_done_add", bus.wb_done, 16'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_done_and", bus.wb_done, 16'h1);
    bus.RdAddrA = 3'd2;
    #1;
    chk("b2b_r2", bus.RdDataA, 16'h11);
    chk("b2b_flags_mid", bus.FlagReg, 16'h2);
    tick();
    bus.RdAddrB = 3'd4;
    #1;
    chk("b2b_done_idle", bus.wb_done, 16'h0);
    chk("b2b_r4", bus.RdDataB, 16'h00);
    chk("b2b_flags", bus.FlagReg, 16'h3);

    // Reset arriving in WR_HI of a MUL aborts the high-byte write.
    do_reset();
    drive_op(OP_MUL, 16'hABCD, 1'b0, 1'b0, 3'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("rmul_ready_wr_lo", bus.in_ready, 16'h0);
    tick();
    bus.RdAddrA = 3'd5;
    #1;
    chk("rmul_r5_lo", bus.RdDataA, 16'hCD);
    chk("rmul_done_wr_hi", bus.wb_done, 16'h1);
    rst = 1'b1;
    #1;
    chk("rmul_done_in_rst", bus.wb_done, 16'h0);
    tick();
    chk("rmul_ready_in_rst", bus.in_ready, 16'h0);
    chk("rmul_flags", bus.FlagReg, 16'h0);
    check_all_zero("rmul_rst");
    rst = 1'b0;
    tick();
    chk("rmul_idle_ready", bus.in_ready, 16'h1);
    check_all_zero("rmul_after");

    // Read during write: old value in the WR_LO cycle, new value after.
    do_reset();
    drive_op(OP_OR, 16'h0055, 1'b0, 1'b0, 3'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    drive_op(OP_SUB, 16'h0000, 1'b0, 1'b1, 3'd1);
    bus.RdAddrA = 3'd1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("rdw_old_value", bus.RdDataA, 16'h55);
    chk("rdw_done", bus.wb_done, 16'h1);
    tick();
    chk("rdw_new_value", bus.RdDataA, 16'h00);
    chk("rdw_flags", bus.FlagReg, 16'h1);

    // Randomized traffic against the timed-event model.
    do_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_flags    = 2'b00;
    busy_until = -1;
    evq        = {};
    done_q     = {};
    run_random(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the 8-bit ALU.
- Captures the ALU's 16-bit Result, flagC and flagZ with a valid/ready handshake.
- Writes the result into an 8-entry x 8-bit register file and updates a 2-bit flag register.
- Exposes two asynchronous read ports; the operand-fetch logic uses them to drive Operand1/Operand2.
- MUL results are written as two bytes over two cycles. All other opcodes retire in one write cycle.

Parameters:
- REG_COUNT, 8, number of registers; must be a power of two.
- ADDR_W, 3, register address width; equals log2(REG_COUNT).
- DATA_W, 8, register width; equals the ALU operand width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a completed ALU operation.
- in_ready  output  1  stage can accept this cycle.
- Opcode  input  3  ALU opcode: ADD=000, SUB=001, MUL=010, AND=011, OR=100, NAND=101, NOR=110, XOR=111.
- Result  input  16  ALU result.
- flagC  input  1  ALU carry; meaningful for ADD/SUB only.
- flagZ  input  1  ALU zero flag, computed over all 16 bits.
- DestAddr  input  ADDR_W  destination register.
- RdAddrA  input  ADDR_W  read port A address.
- RdAddrB  input  ADDR_W  read port B address.
- RdDataA  output  DATA_W  combinational read of register RdAddrA.
- RdDataB  output  DATA_W  combinational read of register RdAddrB.
- FlagReg  output  2  registered flags: {C, Z}.
- wb_done  output  1  one-cycle pulse in the cycle the final byte of an operation is written.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.

Reset:
- While rst=1, at every clk edge: all registers clear to 0x00, FlagReg to 2'b00, state to IDLE, wb_done to 0, capture latches to 0.
- in_ready=0 while rst=1.
- Reset mid-operation aborts any pending write; no register is modified on that edge.

State machine: states IDLE, WR_LO, WR_HI.
- Accept = in_valid & in_ready. An accept latches Opcode, Result, flagC, flagZ and DestAddr.
- in_ready = 1 in IDLE, or in WR_LO when the latched opcode is not MUL. in_ready = 0 in WR_HI, and in WR_LO for MUL.
- IDLE: on accept, go to WR_LO; otherwise stay in IDLE.
- WR_LO, at the edge ending the cycle:
  - reg[Dest] <= Result[7:0].
  - FlagReg.Z <= latched flagZ.
  - FlagReg.C <= latched flagC for ADD/SUB; C holds its previous value for all other opcodes.
  - Next state: MUL goes to WR_HI. Otherwise, an accept in the same cycle goes to WR_LO with the new operation latched; no accept goes to IDLE.
- WR_HI:
  - reg[(Dest+1) mod REG_COUNT] <= Result[15:8]; address wraps, so 7+1 -> 0.
  - Flags unchanged.
  - Next state: IDLE.
- wb_done = 1 in WR_LO for non-MUL operations and in WR_HI for MUL. It is combinational from state and latched opcode, and 0 during reset.

Latency and throughput:
- Accept in cycle N: low byte is visible on the read ports from cycle N+2. For MUL, the high byte is visible from N+3.
- Throughput: one non-MUL operation per cycle with in_valid held; MUL occupies 3 cycles, including the accept cycle.

Boundary conditions:
- Read during write: RdData returns the old value in the write cycle. There is no bypass.
- RdAddrA = RdAddrB is legal; both ports return the same data.
- Simultaneous write completion and a new accept in WR_LO: the old operation's write and the new capture happen on the same edge, with no loss or duplication.
- in_valid while in_ready=0: no capture. Upstream must hold its inputs until accepted.
- Result[15:8] is ignored for non-MUL opcodes.

Test Plan:
- Reset: hold rst 2 cycles, release -> all RdData 0x00, FlagReg 00, in_ready 1, wb_done 0.
- ADD: Result=0x012C, flagC=1, flagZ=0, Dest=3 -> R3=0x2C readable 2 cycles after accept, FlagReg=10, wb_done pulses once.
- MUL wrap: Result=0xBEEF, flagZ=0, Dest=7 -> R7=0xEF, then R0=0xBE one cycle later. in_ready low during WR_LO/WR_HI. C unchanged from before.
- Back-to-back: ADD (C=1) then AND Result=0x0000, Dest 2 and 4, in_valid held 2 cycles -> both accepted on consecutive cycles, R2/R4 written, final FlagReg=11 (C retained, Z set).
- Reset mid-MUL: assert rst during WR_HI of MUL to Dest=5 -> R6 stays 0x00, all registers 0x00, state IDLE.
- Read-during-write: SUB Result=0x0000, Dest=1, R1 preloaded with 0x55, RdAddrA=1 -> RdDataA=0x55 during the WR_LO cycle, 0x00 the next cycle, FlagReg=01.
